// File: rtl/mux_display_scanner.sv
// N-digit time-multiplexed hex display driver with refresh prescaler, blanking,
// tear-free double-buffered value, per-digit enables and leading-zero suppression.
module mux_display_scanner #(
    parameter int unsigned N_DIGITS         = 8,
    parameter int unsigned PRESCALE         = 1000,
    parameter int unsigned BLANK_CYCLES     = 16,
    parameter bit          ANODE_ACTIVE_LOW = 1'b0,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    lz_suppress,
    input  logic                    load,
    output logic [N_DIGITS-1:0]     anode,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [3:0]              dnum,
    output logic                    scan_done
);

    localparam int unsigned SLOT_W = $clog2(PRESCALE);
    localparam int unsigned IDX_W  = $clog2(N_DIGITS);
    localparam int unsigned DW     = 4 * N_DIGITS;

    localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(PRESCALE - 1);
    localparam logic [SLOT_W-1:0]   SLOT_LIT  = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]    IDX_TOP   = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [6:0]          SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic                DP_OFF    = SEG_ACTIVE_LOW;

    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DW-1:0]       pend_dig_q, pend_dig_d;
    logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [DW-1:0]       disp_dig_q, disp_dig_d;
    logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic                bnd_q, bnd_d;
    logic [N_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [3:0]          dnum_q, dnum_d;
    logic                done_q, done_d;

    logic                slot_end;
    logic                frame_end;
    logic [N_DIGITS-1:0] supp;
    logic                lead_zero;
    logic [3:0]          nib;
    logic                lit;
    logic [N_DIGITS-1:0] an_raw;
    logic [6:0]          seg_raw;
    logic                dp_raw;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan counters and value buffers; display buffer only moves at the frame boundary.
    always_comb begin
        slot_end   = (slot_q == SLOT_LAST);
        frame_end  = slot_end && (idx_q == '0);
        slot_d     = slot_end ? '0 : slot_q + SLOT_W'(1);
        idx_d      = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == '0) ? IDX_TOP : idx_q - IDX_W'(1);
        end
        pend_dig_d = load ? digits_in : pend_dig_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;
        disp_dig_d = frame_end ? pend_dig_d : disp_dig_q;
        disp_dp_d  = frame_end ? pend_dp_d : disp_dp_q;
        bnd_d      = frame_end;
    end

    // A digit is suppressed while it and every digit to its left hold zero.
    always_comb begin
        supp      = '0;
        lead_zero = lz_suppress;
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            lead_zero = lead_zero && (disp_dig_q[4*i +: 4] == 4'h0);
            supp[i]   = lead_zero;
        end
    end

    always_comb begin
        an_raw  = '0;
        nib     = disp_dig_q[{idx_q, 2'b00} +: 4];
        lit     = (slot_q >= SLOT_LIT) && digit_en[idx_q] && !supp[idx_q];
        if (lit) begin
            an_raw[idx_q] = 1'b1;
        end
        seg_raw = lit ? hex7(nib) : 7'h00;
        dp_raw  = lit && disp_dp_q[idx_q];
        anode_d = an_raw ^ AN_OFF;
        seg_d   = seg_raw ^ SEG_OFF;
        dp_d    = dp_raw ^ DP_OFF;
        dnum_d  = nib;
        done_d  = bnd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            idx_q      <= IDX_TOP;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            disp_dig_q <= '0;
            disp_dp_q  <= '0;
            bnd_q      <= 1'b0;
            anode_q    <= AN_OFF;
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
            dnum_q     <= 4'h0;
            done_q     <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            disp_dig_q <= disp_dig_d;
            disp_dp_q  <= disp_dp_d;
            bnd_q      <= bnd_d;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            dnum_q     <= dnum_d;
            done_q     <= done_d;
        end
    end

    assign anode     = anode_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign dnum      = dnum_q;
    assign scan_done = done_q;

endmodule

// File: tb/tb_mux_display_scanner.sv
// Scoreboard bench: stimulus queues hand-computed frame expectations, a monitor
// checks each frame cycle by cycle after every scan_done pulse.
module tb_mux_display_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_suppress;
    logic        load;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dnum;
    logic        scan_done;

    typedef struct {
        logic [15:0] dn;
        logic [3:0]  lit;
        logic [27:0] segs;
        logic [3:0]  dps;
    } frame_t;

    frame_t q[$];
    int total = 0;
    int bad   = 0;

    mux_display_scanner #(
        .N_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2),
        .ANODE_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
        .digit_en(digit_en), .lz_suppress(lz_suppress), .load(load),
        .anode(anode), .seg(seg), .dp(dp), .dnum(dnum), .scan_done(scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] dn, input logic [3:0] lit,
                        input logic [27:0] segs, input logic [3:0] dps);
        frame_t f;
        f.dn = dn; f.lit = lit; f.segs = segs; f.dps = dps;
        q.push_back(f);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sd();
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (scan_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("scan_done seen", int'(seen), 1);
    endtask

    // Monitor: each scan_done opens a 32-cycle frame checked against the next queued entry.
    initial begin
        int     cnt = 0;
        int     last = 0;
        int     k = 0;
        int     d;
        int     pos;
        bit     sdv = 1'b0;
        bit     active = 1'b0;
        bit     ok = 1'b1;
        frame_t e;
        logic [3:0] ea;
        logic [6:0] es;
        logic       edp;
        logic [3:0] en;
        forever begin
            @(negedge clk);
            cnt++;
            if (rst) begin
                active = 1'b0;
                sdv    = 1'b0;
            end else begin
                if (scan_done === 1'b1) begin
                    if (sdv) chk("scan_done period", cnt - last, 32);
                    last = cnt;
                    sdv  = 1'b1;
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        active = 1'b1;
                        k = 0;
                        ok = 1'b1;
                    end else begin
                        active = 1'b0;
                    end
                end
                if (active) begin
                    d   = 3 - k / 8;
                    pos = k % 8;
                    en  = e.dn[4*d +: 4];
                    ea  = 4'h0;
                    es  = 7'h00;
                    edp = 1'b0;
                    if (pos >= 2 && e.lit[d]) begin
                        ea  = 4'(1 << d);
                        es  = e.segs[7*d +: 7];
                        edp = e.dps[d];
                    end
                    if (anode !== ea || seg !== es || dp !== edp || dnum !== en) begin
                        if (ok)
                            $display("FAIL frame digit%0d pos%0d: got an=%b seg=%h dp=%b dnum=%h, want an=%b seg=%h dp=%b dnum=%h",
                                     d, pos, anode, seg, dp, dnum, ea, es, edp, en);
                        ok = 1'b0;
                    end
                    if (pos == 7) begin
                        total++;
                        if (!ok) bad++;
                        ok = 1'b1;
                    end
                    k++;
                    if (k == 32) active = 1'b0;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; digits_in = 16'h0; dp_in = 4'h0; digit_en = 4'hF;
        lz_suppress = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset anode", int'(anode), 0);
        chk("reset seg", int'(seg), 0);
        chk("reset scan_done", int'(scan_done), 0);
        #1 rst = 1'b0;

        digits_in = 16'h1234; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        push(16'h1234, 4'hF, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0);
        push(16'hABCD, 4'hF, {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'h0);

        // Mid-frame load must not tear the frame being shown.
        wait_sd();
        cyc(20);
        digits_in = 16'hABCD; load = 1'b1;
        cyc(1);
        load = 1'b0;
        push(16'h0050, 4'b0011, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'h0);

        // Load exactly on the boundary cycle goes straight to display.
        wait_sd();
        cyc(30);
        digits_in = 16'h0050; load = 1'b1; lz_suppress = 1'b1;
        cyc(1);
        load = 1'b0;
        push(16'h0000, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'h0);

        wait_sd();
        cyc(5);
        digits_in = 16'h0000; load = 1'b1;
        cyc(1);
        load = 1'b0;
        push(16'h5678, 4'b1010, {7'h6D, 7'h00, 7'h07, 7'h00}, 4'b0010);

        wait_sd();
        cyc(5);
        digits_in = 16'h5678; dp_in = 4'b0011; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(25);
        digit_en = 4'b1010; lz_suppress = 1'b0;

        wait_sd();
        wait_sd();
        cyc(2);
        digits_in = 16'h9999; dp_in = 4'hF; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(15);
        chk("pre-reset anode lit", int'(anode), 4'b0010);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        chk("async rst anode", int'(anode), 0);
        chk("async rst seg", int'(seg), 0);
        chk("async rst dp", int'(dp), 0);
        chk("async rst scan_done", int'(scan_done), 0);
        chk("async rst dnum", int'(dnum), 0);
        digit_en = 4'hF;
        push(16'h0000, 4'hF, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'h0);
        @(negedge clk);
        #2 rst = 1'b0;

        @(negedge clk);
        chk("restart dnum", int'(dnum), 0);
        chk("restart blank0 anode", int'(anode), 0);
        chk("restart blank0 seg", int'(seg), 0);
        @(negedge clk);
        chk("restart blank1 anode", int'(anode), 0);
        @(negedge clk);
        chk("restart lit anode", int'(anode), 4'b1000);
        chk("restart lit seg", int'(seg), 7'h3F);

        wait_sd();
        cyc(33);
        chk("scoreboard drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_display_scanner.md
Name: mux_display_scanner

Overview:
Parametrised N-digit time-multiplexed hex display driver. It is the successor to the fixed 4-digit, one-digit-per-clock switch scanner. It adds:
- a refresh prescaler and an inter-digit blanking interval (anti-ghosting),
- a double-buffered value latch so a frame never shows a torn value,
- per-digit enables and leading-zero suppression,
- an on-chip hex-to-7-segment decode.

It sits between the value source (switches or core registers) and the board's anode/segment pins.

Parameters:
N_DIGITS, 8, number of digits scanned (2..16).
PRESCALE, 1000, clk cycles per digit slot (must be > BLANK_CYCLES, >= 2).
BLANK_CYCLES, 16, cycles at start of each slot with all anodes inactive (0 = no blanking).
ANODE_ACTIVE_LOW, 0, 1 = anode outputs inverted at the pins.
SEG_ACTIVE_LOW, 1, 1 = seg/dp outputs inverted at the pins.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
digits_in  input  4*N_DIGITS  hex nibbles; nibble i = bits [4i+3:4i]; digit N_DIGITS-1 is leftmost
dp_in  input  N_DIGITS  decimal point per digit
digit_en  input  N_DIGITS  1 = digit may light; sampled live, not buffered
lz_suppress  input  1  enable leading-zero blanking; sampled live
load  input  1  1-cycle strobe: capture digits_in/dp_in into pending buffer
anode  output  N_DIGITS  one-hot digit select (polarity per ANODE_ACTIVE_LOW)
seg  output  7  segments {g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
dp  output  1  decimal point (polarity per SEG_ACTIVE_LOW)
dnum  output  4  raw nibble of the digit currently in its slot
scan_done  output  1  1-cycle pulse at end of each full frame

Behaviour:
- Reset (async assert, sync release): all counters and buffers 0; digit index = N_DIGITS-1; scan_done=0; dnum=0; anode all inactive; seg/dp all off. Inactive/off means the electrical level after the polarity parameters are applied.
- slot_cnt counts 0..PRESCALE-1 and wraps. On wrap, the digit index decrements, N_DIGITS-1 down to 0, then wraps back to N_DIGITS-1. Scan order is leftmost digit first.
- Frame length = N_DIGITS*PRESCALE cycles.
- All outputs are registered: they reflect the counter state of the previous cycle (1-cycle latency).
- Anode for digit d is active only while index==d and slot_cnt >= BLANK_CYCLES. During blanking all anodes are inactive and seg/dp are off. dnum is valid for the whole slot, including blanking.
- load captures digits_in/dp_in into the pending buffer; a later load overwrites it.
- At frame boundary (index==0 and slot_cnt==PRESCALE-1), pending is copied to the display buffer. If load is high in that same cycle, digits_in/dp_in go straight into both buffers.
- The display buffer never changes mid-frame.
- Leading-zero suppression: if lz_suppress=1, digit d is suppressed when every display-buffer nibble from N_DIGITS-1 down to d is 0. Digit 0 is never suppressed.
- A suppressed digit, or one with digit_en[d]=0, keeps its anode inactive for the whole slot. Its slot time is still consumed, so refresh rate stays constant. dp is also off for that slot.
- Decode: standard hex 0-F to 7-segment (0=0x3F, 1=0x06, ..., 8=0x7F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71, active-high form), inverted when SEG_ACTIVE_LOW=1.
- scan_done pulses high for exactly one cycle, in the same cycle the new display buffer first drives dnum for digit N_DIGITS-1.
- Reset mid-frame: outputs go to reset values immediately. The scan restarts at digit N_DIGITS-1 with slot_cnt=0, and the pending load is discarded.

Test Plan:
(Bench uses N_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0.)
1. Reset then load digits_in=16'h1234, digit_en=4'hF, lz_suppress=0 -> after the first frame boundary, each 8-cycle slot gives 2 cycles anode=0000 then 6 cycles of 1000/0100/0010/0001, with dnum 1,2,3,4 and seg 0x06,0x5B,0x4F,0x66.
2. Frame timing -> scan_done pulses exactly every 32 cycles, width 1.
3. Tear-free update: load 16'hABCD mid-frame while showing 16'h1234 -> remaining slots still show 3,4; next frame shows A,b,C,d. Load asserted exactly at the boundary cycle -> new value appears on the immediately following frame.
4. lz_suppress=1, value 16'h0050 -> digits 3 and 2 anode stay 0000 for their full slots; digit 1 shows 5, digit 0 shows 0. Value 16'h0000 -> only digit 0 lights, showing 0x3F.
5. digit_en=4'b1010, dp_in=4'b0011 -> only anodes 1000 and 0010 ever assert; dp=1 only during digit 1's active window; the period is still 32 cycles.
6. Assert rst asynchronously mid-slot (between clk edges) -> anode=0000, seg=0 and scan_done=0 without waiting for an edge. After release, digit 3 slot restarts with dnum=0 and a 2-cycle blank.
